// File: rtl/vproc_wr_scoreboard_if.sv
// Issue/write-back/retire bundle between decoder, execution units and the
// vector register write scoreboard.
interface vproc_wr_scoreboard_if #(
    parameter int MAX_OP_W = 2
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_pend_wr_i;
    logic [31:0]         issue_pend_rd_i;
    logic [MAX_OP_W-1:0] issue_id_o;
    logic                wr_valid_i;
    logic [MAX_OP_W-1:0] wr_id_i;
    logic [4:0]          wr_addr_i;
    logic                retire_valid_i;
    logic [MAX_OP_W-1:0] retire_id_i;
    logic                flush_i;
    logic [31:0]         pending_wr_o;
    logic [MAX_OP_W:0]   free_cnt_o;
    logic                err_o;

    modport master (
        output issue_valid_i, issue_pend_wr_i, issue_pend_rd_i,
        output wr_valid_i, wr_id_i, wr_addr_i,
        output retire_valid_i, retire_id_i, flush_i,
        input  issue_ready_o, issue_id_o, pending_wr_o, free_cnt_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_pend_wr_i, issue_pend_rd_i,
        input  wr_valid_i, wr_id_i, wr_addr_i,
        input  retire_valid_i, retire_id_i, flush_i,
        output issue_ready_o, issue_id_o, pending_wr_o, free_cnt_o, err_o
    );
endinterface

// File: rtl/vproc_wr_scoreboard.sv
// Outstanding vector register write tracker; gates issue on RAW/WAW hazards.
// Optional VPROC_SCB_BYPASS_EN: hazard check ignores bits being cleared this cycle.
module vproc_wr_scoreboard #(
    parameter int MAX_OP_W       = 2,
    parameter bit DONT_CARE_ZERO = 1'b0
) (
    input logic                   clk_i,
    input logic                   sync_rst_i,
    vproc_wr_scoreboard_if.slave  sb
);
    localparam int NSLOT = 1 << MAX_OP_W;
    localparam logic [MAX_OP_W:0] CNT_ONE = (MAX_OP_W + 1)'(1);

    logic [NSLOT-1:0]    slot_valid;
    logic [31:0]         slot_mask [NSLOT];
    logic                err_q;

    logic [31:0]         pend_union;
    logic [31:0]         haz_union;
    logic [MAX_OP_W:0]   free_cnt;
    logic                free_any;
    logic [MAX_OP_W-1:0] free_idx;
    logic                wr_ok, wr_bad, ret_ok, ret_bad;
    logic                hazard, ready, fire;

    always_comb begin
        pend_union = '0;
        free_cnt   = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_valid[i]) begin
                pend_union = pend_union | slot_mask[i];
            end else begin
                free_cnt = free_cnt + CNT_ONE;
                free_any = 1'b1;
                free_idx = MAX_OP_W'(i);
            end
        end
    end

    // Slots being allocated are invalid here, so legality needs only registered state.
    assign wr_ok   = sb.wr_valid_i     &  slot_valid[sb.wr_id_i];
    assign wr_bad  = sb.wr_valid_i     & ~slot_valid[sb.wr_id_i];
    assign ret_ok  = sb.retire_valid_i &  slot_valid[sb.retire_id_i];
    assign ret_bad = sb.retire_valid_i & ~slot_valid[sb.retire_id_i];

`ifdef VPROC_SCB_BYPASS_EN
    always_comb begin
        logic [31:0] eff;
        haz_union = '0;
        for (int i = 0; i < NSLOT; i++) begin
            eff = slot_valid[i] ? slot_mask[i] : 32'h0;
            if (wr_ok && sb.wr_id_i == MAX_OP_W'(i)) begin
                eff[sb.wr_addr_i] = 1'b0;
            end
            if (ret_ok && sb.retire_id_i == MAX_OP_W'(i)) begin
                eff = '0;
            end
            haz_union = haz_union | eff;
        end
    end
`else
    assign haz_union = pend_union;
`endif

    assign hazard = |((sb.issue_pend_rd_i | sb.issue_pend_wr_i) & haz_union);
    assign ready  = free_any & ~hazard & ~sb.flush_i;
    assign fire   = sb.issue_valid_i & ready;

    assign sb.issue_ready_o = ready;
    assign sb.issue_id_o    = free_any ? free_idx
                                       : (DONT_CARE_ZERO ? '0 : 'x);
    assign sb.pending_wr_o  = pend_union;
    assign sb.free_cnt_o    = free_cnt;
    assign sb.err_o         = err_q;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i || sb.flush_i) begin
            slot_valid <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_mask[i] <= '0;
            end
        end else begin
            err_q <= wr_bad | ret_bad;
            // Retire beats a same-slot write; allocation only targets invalid slots.
            for (int i = 0; i < NSLOT; i++) begin
                if (ret_ok && sb.retire_id_i == MAX_OP_W'(i)) begin
                    slot_valid[i] <= 1'b0;
                    slot_mask[i]  <= '0;
                end else if (fire && free_idx == MAX_OP_W'(i)) begin
                    slot_valid[i] <= 1'b1;
                    slot_mask[i]  <= sb.issue_pend_wr_i;
                end else if (wr_ok && sb.wr_id_i == MAX_OP_W'(i)) begin
                    slot_mask[i][sb.wr_addr_i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vproc_wr_scoreboard.sv
// Self-checking bench: directed vector table, then random traffic against a slot model.
module tb_vproc_wr_scoreboard;
    localparam int MAX_OP_W = 2;
    localparam int NSLOT    = 4;
`ifdef VPROC_SCB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vproc_wr_scoreboard_if #(.MAX_OP_W(MAX_OP_W)) sbif ();

    vproc_wr_scoreboard #(.MAX_OP_W(MAX_OP_W), .DONT_CARE_ZERO(1'b1)) dut (
        .clk_i      (clk),
        .sync_rst_i (rst),
        .sb         (sbif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid [NSLOT];
    logic [31:0] m_mask  [NSLOT];
    bit          m_err;

    typedef struct {
        bit iv; logic [31:0] pw; logic [31:0] pr;
        bit wv; logic [1:0] wid; logic [4:0] wa;
        bit rv; logic [1:0] rid; bit fl;
        bit e_rdy; logic [1:0] e_id; logic [31:0] e_pend; logic [2:0] e_free; bit e_err;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [31:0] pw, input logic [31:0] pr,
                         input bit wv, input logic [1:0] wid, input logic [4:0] wa,
                         input bit rv, input logic [1:0] rid, input bit fl);
        sbif.issue_valid_i   = iv;
        sbif.issue_pend_wr_i = pw;
        sbif.issue_pend_rd_i = pr;
        sbif.wr_valid_i      = wv;
        sbif.wr_id_i         = wid;
        sbif.wr_addr_i       = wa;
        sbif.retire_valid_i  = rv;
        sbif.retire_id_i     = rid;
        sbif.flush_i         = fl;
    endtask

    function automatic vec_t mk(bit iv, logic [31:0] pw, logic [31:0] pr,
                                bit wv, logic [1:0] wid, logic [4:0] wa,
                                bit rv, logic [1:0] rid, bit fl,
                                bit e_rdy, logic [1:0] e_id, logic [31:0] e_pend,
                                logic [2:0] e_free, bit e_err);
        vec_t v;
        v.iv = iv; v.pw = pw; v.pr = pr; v.wv = wv; v.wid = wid; v.wa = wa;
        v.rv = rv; v.rid = rid; v.fl = fl;
        v.e_rdy = e_rdy; v.e_id = e_id; v.e_pend = e_pend; v.e_free = e_free; v.e_err = e_err;
        return v;
    endfunction

    // ---------------- reference model ----------------
    function automatic void m_clear();
        for (int i = 0; i < NSLOT; i++) begin
            m_valid[i] = 1'b0;
            m_mask[i]  = '0;
        end
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] m_union();
        logic [31:0] u = '0;
        for (int i = 0; i < NSLOT; i++) if (m_valid[i]) u |= m_mask[i];
        return u;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < NSLOT; i++) if (!m_valid[i]) n++;
        return n;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < NSLOT; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    // Pending set the incoming instruction is compared against.
    function automatic logic [31:0] m_haz_set();
        logic [31:0] u = '0;
        logic [31:0] s;
        if (!BYP) return m_union();
        for (int i = 0; i < NSLOT; i++) begin
            if (!m_valid[i]) continue;
            s = m_mask[i];
            if (sbif.retire_valid_i && int'(sbif.retire_id_i) == i) s = '0;
            if (sbif.wr_valid_i && int'(sbif.wr_id_i) == i) s[sbif.wr_addr_i] = 1'b0;
            u |= s;
        end
        return u;
    endfunction

    function automatic bit m_ready();
        if (sbif.flush_i) return 1'b0;
        if (m_free() == 0) return 1'b0;
        return ((sbif.issue_pend_rd_i | sbif.issue_pend_wr_i) & m_haz_set()) == 32'h0;
    endfunction

    function automatic void m_step(input bit do_rst);
        bit wr_ok, ret_ok, fire;
        int lo;
        if (do_rst || sbif.flush_i) begin
            m_clear();
            return;
        end
        wr_ok  = sbif.wr_valid_i && m_valid[sbif.wr_id_i];
        ret_ok = sbif.retire_valid_i && m_valid[sbif.retire_id_i];
        fire   = sbif.issue_valid_i && m_ready();
        lo     = m_lowest();
        m_err  = (sbif.wr_valid_i && !wr_ok) || (sbif.retire_valid_i && !ret_ok);
        if (wr_ok && !(ret_ok && sbif.retire_id_i == sbif.wr_id_i))
            m_mask[sbif.wr_id_i][sbif.wr_addr_i] = 1'b0;
        if (ret_ok) begin
            m_valid[sbif.retire_id_i] = 1'b0;
            m_mask[sbif.retire_id_i]  = '0;
        end
        if (fire) begin
            m_valid[lo] = 1'b1;
            m_mask[lo]  = sbif.issue_pend_wr_i;
        end
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_clear();
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.iv, v.pw, v.pr, v.wv, v.wid, v.wa, v.rv, v.rid, v.fl);
        #2;
        chk($sformatf("vec%0d ready", idx), 32'(sbif.issue_ready_o), 32'(v.e_rdy));
        chk($sformatf("vec%0d id", idx), 32'(sbif.issue_id_o), 32'(v.e_id));
        @(posedge clk); #1;
        chk($sformatf("vec%0d pending", idx), sbif.pending_wr_o, v.e_pend);
        chk($sformatf("vec%0d free", idx), 32'(sbif.free_cnt_o), 32'(v.e_free));
        chk($sformatf("vec%0d err", idx), 32'(sbif.err_o), 32'(v.e_err));
    endtask

    task automatic rand_cycle(input int n);
        bit do_rst;
        logic [31:0] pw, pr;
        do_rst = ($urandom_range(0, 99) == 0);
        pw = ($urandom_range(0, 3) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 7));
        pr = ($urandom_range(0, 1) == 0) ? 32'h0 : (32'h1 << $urandom_range(0, 7));
        drive($urandom_range(0, 2) != 0, pw, pr,
              $urandom_range(0, 4) < 2, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
              $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 49) == 0);
        rst = do_rst;
        #2;
        if (!do_rst) begin
            chk($sformatf("rnd%0d ready", n), 32'(sbif.issue_ready_o), 32'(m_ready()));
            chk($sformatf("rnd%0d id", n), 32'(sbif.issue_id_o),
                32'((m_lowest() < 0) ? 0 : m_lowest()));
        end
        m_step(do_rst);
        @(posedge clk); #1;
        rst = 1'b0;
        chk($sformatf("rnd%0d pending", n), sbif.pending_wr_o, m_union());
        chk($sformatf("rnd%0d free", n), 32'(sbif.free_cnt_o), 32'(m_free()));
        chk($sformatf("rnd%0d err", n), 32'(sbif.err_o), 32'(m_err));
    endtask

    initial begin
        //            iv pw           pr    wv wid wa rv rid fl  rdy id pend         free err
        tbl[0]  = mk(1, 32'h3,       32'h0, 0, 0, 0, 0, 0, 0,   1,  0, 32'h3,       3, 0);
        tbl[1]  = mk(1, 32'h0,       32'h2, 0, 0, 0, 0, 0, 0,   0,  1, 32'h3,       3, 0);
        tbl[2]  = mk(0, 32'h0,       32'h2, 1, 0, 1, 0, 0, 0,   BYP, 1, 32'h1,      3, 0);
        tbl[3]  = mk(1, 32'h0,       32'h2, 0, 0, 0, 0, 0, 0,   1,  1, 32'h1,       2, 0);
        tbl[4]  = mk(0, 32'h0,       32'h0, 0, 0, 0, 1, 0, 0,   1,  2, 32'h0,       3, 0);
        tbl[5]  = mk(0, 32'h0,       32'h0, 0, 0, 0, 1, 1, 0,   1,  0, 32'h0,       4, 0);
        tbl[6]  = mk(1, 32'h1,       32'h0, 0, 0, 0, 0, 0, 0,   1,  0, 32'h1,       3, 0);
        tbl[7]  = mk(1, 32'h2,       32'h0, 0, 0, 0, 0, 0, 0,   1,  1, 32'h3,       2, 0);
        tbl[8]  = mk(1, 32'h4,       32'h0, 0, 0, 0, 0, 0, 0,   1,  2, 32'h7,       1, 0);
        tbl[9]  = mk(1, 32'h8,       32'h0, 0, 0, 0, 0, 0, 0,   1,  3, 32'hF,       0, 0);
        tbl[10] = mk(1, 32'h10,      32'h0, 0, 0, 0, 1, 2, 0,   0,  0, 32'hB,       1, 0);
        tbl[11] = mk(1, 32'h10,      32'h0, 0, 0, 0, 0, 0, 0,   1,  2, 32'h1B,      0, 0);
        tbl[12] = mk(0, 32'h0,       32'h0, 1, 1, 1, 1, 1, 0,   0,  0, 32'h19,      1, 0);
        tbl[13] = mk(0, 32'h0,       32'h0, 0, 0, 0, 1, 1, 0,   1,  1, 32'h19,      1, 1);
        tbl[14] = mk(0, 32'h0,       32'h0, 0, 0, 0, 0, 0, 0,   1,  1, 32'h19,      1, 0);
        tbl[15] = mk(1, 32'h20,      32'h0, 0, 0, 0, 0, 0, 1,   0,  1, 32'h0,       4, 0);
        tbl[16] = mk(1, 32'h10,      32'h0, 0, 0, 0, 0, 0, 0,   1,  0, 32'h10,      3, 0);
        tbl[17] = mk(1, 32'h10,      32'h0, 0, 0, 0, 0, 0, 0,   0,  1, 32'h10,      3, 0);
        tbl[18] = mk(1, 32'h0,       32'h0, 0, 0, 0, 0, 0, 0,   1,  1, 32'h10,      2, 0);
        tbl[19] = mk(0, 32'h0,       32'h0, 1, 3, 0, 0, 0, 0,   1,  2, 32'h10,      2, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("reset pending", sbif.pending_wr_o, 32'h0);
        chk("reset free", 32'(sbif.free_cnt_o), 32'd4);
        chk("reset err", 32'(sbif.err_o), 32'd0);
        chk("reset ready", 32'(sbif.issue_ready_o), 32'd1);
        chk("reset id", 32'(sbif.issue_id_o), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) apply_vec(tbl[i], i);

        // Mid-operation reset drops slots; a late write-back then flags an error.
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_reset();
        chk("midrst pending", sbif.pending_wr_o, 32'h0);
        chk("midrst free", 32'(sbif.free_cnt_o), 32'd4);
        drive(0, 0, 0, 1, 0, 6, 0, 0, 0);
        @(posedge clk); #1;
        chk("midrst late wr err", 32'(sbif.err_o), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("midrst err clears", 32'(sbif.err_o), 32'd0);

        do_reset();
        for (int n = 0; n < 2000; n++) rand_cycle(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vproc_wr_scoreboard.md
# vproc_wr_scoreboard

Tracks outstanding vector register writes for up to 2**MAX_OP_W in-flight vector instructions and gates instruction issue on RAW and WAW hazards. Sits between the decoder, which supplies each instruction's pending-write mask and read mask, and the execution units, which report per-register write-back and instruction retirement. It gives the dispatcher a single ready signal and an instruction ID. It also exports the union of all pending writes to the rest of the core.

## Interface
- MAX_OP_W, default 2: log2 of the number of in-flight instruction slots (default 4 slots).
- DONT_CARE_ZERO, default 1'b0: drive don't-care outputs to zero instead of X.

- clk_i  in  1  clock; all state is updated on the rising edge.
- sync_rst_i  in  1  reset; synchronous, active-high.
- issue_valid_i  in  1  the decoder presents an instruction.
- issue_ready_o  out  1  the instruction is accepted this cycle; fire = valid & ready.
- issue_pend_wr_i  in  32  vregs the instruction will write, as produced by the pending-write mask generator.
- issue_pend_rd_i  in  32  vregs the instruction reads.
- issue_id_o  out  MAX_OP_W  slot ID assigned on fire.
- wr_valid_i  in  1  a unit has completed the write of one vreg.
- wr_id_i  in  MAX_OP_W  slot ID of the writing instruction.
- wr_addr_i  in  5  vreg address written.
- retire_valid_i  in  1  an instruction has completed.
- retire_id_i  in  MAX_OP_W  slot ID of the retiring instruction.
- flush_i  in  1  discard all slots.
- pending_wr_o  out  32  OR of the masks of all valid slots.
- free_cnt_o  out  MAX_OP_W+1  number of free slots.
- err_o  out  1  one-cycle pulse on an illegal wr or retire.

## Operation
- Per slot state: a valid bit and a 32-bit mask.
- Hazard condition: (issue_pend_rd_i | issue_pend_wr_i) & pend_union != 0.
  - Covers RAW (a read of a pending vreg) and WAW (a write to a pending vreg).
  - WAR is not checked; in-order reads are guaranteed upstream.
- issue_ready_o = (free_cnt != 0) & ~hazard.
- issue_id_o = lowest-index free slot.
  - When no slot is free, it is '0 if DONT_CARE_ZERO is set, else 'x.
- On fire: the slot becomes valid with mask = issue_pend_wr_i.
  - An all-zero mask is legal, e.g. a store or an xreg result. The slot is still allocated until it retires.
- wr_valid_i: clears bit wr_addr_i in the mask of slot wr_id_i.
  - Writing a bit that is already clear in a valid slot has no effect and raises no error.
  - A write to a slot that is not valid pulses err_o; state is unchanged.
- retire_valid_i: clears the slot's valid bit and its whole mask, whether or not bits remain.
  - Retiring a slot that is not valid pulses err_o.
- Simultaneous events in one cycle:
  - A wr and a retire on the same slot: retire wins.
  - A slot being retired is never reallocated in the same cycle. The issue ID is chosen from the registered valid bits.
  - A wr or retire on a slot being allocated in the same cycle is illegal: it pulses err_o and is ignored.
- flush_i: clears all slots next edge. It overrides every other event in that cycle, and issue_ready_o is forced to 0.
- Reset values:
  - All slots invalid.
  - pending_wr_o = 0.
  - free_cnt_o = 2**MAX_OP_W.
  - err_o = 0.

## Timing
- issue_ready_o and issue_id_o are combinational from registered state and the issue_* inputs. There is no dependency from valid to ready.
- pending_wr_o and free_cnt_o are computed from registered state only.
  - A fire at cycle N is visible in them at N+1.
  - A wr or retire at cycle N is reflected at N+1.
- err_o is registered and pulses at N+1 for an illegal event at cycle N.
- Reset applied mid-operation drops all slots at the next edge. Any in-flight wr or retire that arrives afterwards pulses err_o.
- Back-to-back issue at one instruction per cycle is possible while slots are free and no hazard exists. The hazard check uses registered state, so each instruction sees all earlier fires.

## Configuration
- VPROC_SCB_BYPASS_EN defined: the hazard check uses pend_union with bits cleared this cycle removed. Cleared bits are those from the wr_valid_i bit and from the retire_valid_i slot mask. A dependent instruction can therefore issue in the same cycle as the clearing write-back. Slot reuse still waits one cycle.
- Undefined: the hazard check uses registered pend_union only, adding one cycle of latency after each clear. This removes the combinational path from wr/retire to issue_ready_o.

## Test plan
- Reset, then issue wr=0x0000_0003, rd=0 -> ready=1 and id=0; the next cycle pending_wr_o=0x3 and free_cnt_o=3.
- Hold that state, then issue rd=0x2 -> ready=0. Send wr_valid id=0 addr=1:
  - pending_wr_o becomes 0x1;
  - ready=1 one cycle later, or in the same cycle with VPROC_SCB_BYPASS_EN.
- Fill 4 slots with disjoint masks 0x1, 0x2, 0x4, 0x8 -> free_cnt_o=0 and ready=0. Retire id=2 -> the next issue receives id=2.
- Retire id=1 and wr id=1 addr=1 in the same cycle -> slot 1 freed, err_o=0. A retire of id=1 the next cycle -> err_o pulses.
- Apply flush_i with 3 valid slots and a simultaneous issue_valid_i -> ready=0 that cycle; the next cycle pending_wr_o=0 and free_cnt_o=4.
- Issue wr=0, rd=0 (a store) -> a slot is allocated and pending_wr_o is unchanged. A WAW issue wr=0x10 while slot mask=0x10 -> ready=0.
